// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the WS2812-style LED serializer path.
//   - Default NRZ timing constants, in clk_100 cycles (10 ns per cycle)
//   - PIXEL_W: width of one GRB pixel word
//   - state_t: serializer FSM state encoding
//   - max3(): constant helper used to size the shared cycle counter
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package led_pkg;

    localparam int PIXEL_W          = 24;

    localparam int T0H_CYC_DEF      = 35;    // 350 ns high for a '0'
    localparam int T1H_CYC_DEF      = 70;    // 700 ns high for a '1'
    localparam int BIT_CYC_DEF      = 125;   // 1.25 us bit period
    localparam int LATCH_CYC_DEF    = 5000;  // 50 us strip latch gap
    localparam int UNDERRUN_CYC_DEF = 2000;  // 20 us inter-pixel wait limit

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HIGH  = 3'd1,
        ST_LOW   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LATCH = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_ws_bit_timer.sv
// ---------------------------------------------------------------------------
// led_ws_bit_timer
// Shared cycle counter for the serializer plus the compares against the
// timing thresholds. The outputs are plain decodes of the current count;
// the parent FSM qualifies them with its own state.
//   clk_100       in   system clock
//   reset_n       in   asynchronous active-low reset
//   cnt_clr_i     in   load zero into the counter (takes priority over enable)
//   cnt_en_i      in   advance the counter by one
//   bit_val_i     in   value of the bit being sent (selects T1H or T0H)
//   hi_done_o     out  last cycle of the high phase of the current bit
//   bit_done_o    out  last cycle of the full bit period
//   latch_done_o  out  last cycle of the latch gap
//   wait_done_o   out  last cycle of the allowed inter-pixel wait
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module led_ws_bit_timer
    import led_pkg::*;
#(
    parameter int T0H_CYC      = T0H_CYC_DEF,
    parameter int T1H_CYC      = T1H_CYC_DEF,
    parameter int BIT_CYC      = BIT_CYC_DEF,
    parameter int LATCH_CYC    = LATCH_CYC_DEF,
    parameter int UNDERRUN_CYC = UNDERRUN_CYC_DEF,
    parameter int CNT_W        = 13
) (
    input  logic clk_100,
    input  logic reset_n,
    input  logic cnt_clr_i,
    input  logic cnt_en_i,
    input  logic bit_val_i,
    output logic hi_done_o,
    output logic bit_done_o,
    output logic latch_done_o,
    output logic wait_done_o
);

    localparam logic [CNT_W-1:0] HI0_LAST   = CNT_W'(T0H_CYC - 1);
    localparam logic [CNT_W-1:0] HI1_LAST   = CNT_W'(T1H_CYC - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(UNDERRUN_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The high-phase compare follows the bit being sent; the counter keeps
    // running through LOW so the period compare is absolute from the rise.
    assign hi_done_o    = (cnt_q == (bit_val_i ? HI1_LAST : HI0_LAST));
    assign bit_done_o   = (cnt_q == BIT_LAST);
    assign latch_done_o = (cnt_q == LATCH_LAST);
    assign wait_done_o  = (cnt_q == WAIT_LAST);

endmodule

// File: rtl/led_ws_serializer.sv
// ---------------------------------------------------------------------------
// led_ws_serializer
// Takes 24-bit pixel words over valid/ready and drives one WS2812-style NRZ
// line, MSB first. After the pixel flagged last, the line is held low for
// the strip latch gap before new pixels are accepted.
//
// Optional feature (macro LED_WS_UNDERRUN_EN): if upstream leaves a frame
// open for UNDERRUN_CYC cycles, a sticky underrun flag is set and the frame
// is closed with a latch gap. Without the macro, WAIT lasts indefinitely and
// underrun is tied low.
//
// Ports:
//   clk_100       in   100 MHz system clock
//   reset_n       in   asynchronous active-low reset
//   pixel_data    in   pixel word, bit 23 sent first
//   pixel_last    in   pixel_data is the last pixel of the frame
//   pixel_valid   in   upstream offers a pixel
//   pixel_ready   out  pixel accepted on this cycle's edge if valid
//   led_sdi       out  registered serial output
//   busy          out  FSM is not in IDLE
//   underrun      out  sticky underrun flag (0 without the feature)
//   underrun_clr  in   clears underrun (unused without the feature)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module led_ws_serializer
    import led_pkg::*;
#(
    parameter int T0H_CYC      = T0H_CYC_DEF,
    parameter int T1H_CYC      = T1H_CYC_DEF,
    parameter int BIT_CYC      = BIT_CYC_DEF,
    parameter int LATCH_CYC    = LATCH_CYC_DEF,
    parameter int UNDERRUN_CYC = UNDERRUN_CYC_DEF
) (
    input  logic               clk_100,
    input  logic               reset_n,
    input  logic [PIXEL_W-1:0] pixel_data,
    input  logic               pixel_last,
    input  logic               pixel_valid,
    output logic               pixel_ready,
    output logic               led_sdi,
    output logic               busy,
    output logic               underrun,
    input  logic               underrun_clr
);

    localparam int CNT_MAX = max3(LATCH_CYC, UNDERRUN_CYC, BIT_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(PIXEL_W);

    state_t             state_q,   state_d;
    logic [PIXEL_W-1:0] shift_q,   shift_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic               last_q,    last_d;
    logic               led_sdi_q;
    logic               ready_q;
    logic               busy_q;

    logic               xfer;
    logic               cnt_clr;
    logic               cnt_en;
    logic               hi_done;
    logic               bit_done;
    logic               latch_done;
    logic               wait_done;

`ifdef LED_WS_UNDERRUN_EN
    logic               und_set;
    logic               underrun_q, underrun_d;
`endif

    led_ws_bit_timer #(
        .T0H_CYC      (T0H_CYC),
        .T1H_CYC      (T1H_CYC),
        .BIT_CYC      (BIT_CYC),
        .LATCH_CYC    (LATCH_CYC),
        .UNDERRUN_CYC (UNDERRUN_CYC),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk_100      (clk_100),
        .reset_n      (reset_n),
        .cnt_clr_i    (cnt_clr),
        .cnt_en_i     (cnt_en),
        .bit_val_i    (shift_q[PIXEL_W-1]),
        .hi_done_o    (hi_done),
        .bit_done_o   (bit_done),
        .latch_done_o (latch_done),
        .wait_done_o  (wait_done)
    );

    // ready_q is only ever high in IDLE and WAIT, so it alone qualifies a
    // transfer; it stays low through reset and the first cycle after it.
    assign xfer = pixel_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        last_d    = last_q;
        cnt_en    = 1'b0;
`ifdef LED_WS_UNDERRUN_EN
        und_set   = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    shift_d   = pixel_data;
                    last_d    = pixel_last;
                    bit_idx_d = IDX_W'(PIXEL_W - 1);
                    state_d   = ST_HIGH;
                end
            end
            ST_HIGH: begin
                cnt_en = 1'b1;
                if (hi_done) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                cnt_en = 1'b1;
                if (bit_done) begin
                    if (bit_idx_q != '0) begin
                        shift_d   = {shift_q[PIXEL_W-2:0], 1'b0};
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                        state_d   = ST_HIGH;
                    end else if (last_q) begin
                        state_d = ST_LATCH;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
`ifdef LED_WS_UNDERRUN_EN
                cnt_en = 1'b1;
`endif
                if (xfer) begin
                    shift_d   = pixel_data;
                    last_d    = pixel_last;
                    bit_idx_d = IDX_W'(PIXEL_W - 1);
                    state_d   = ST_HIGH;
                end
`ifdef LED_WS_UNDERRUN_EN
                // A late pixel on the final wait cycle still wins.
                else if (wait_done) begin
                    und_set = 1'b1;
                    state_d = ST_LATCH;
                end
`endif
            end
            ST_LATCH: begin
                cnt_en = 1'b1;
                if (latch_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // HIGH->LOW is the only transition that keeps counting; every other
    // state change restarts the count, so the counter can never wrap.
    assign cnt_clr = (state_d != state_q) &&
                     !((state_q == ST_HIGH) && (state_d == ST_LOW));

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            last_q    <= 1'b0;
            led_sdi_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            last_q    <= last_d;
            // Line level follows the state one cycle later; widths and
            // periods are preserved exactly.
            led_sdi_q <= (state_q == ST_HIGH);
            ready_q   <= (state_d == ST_IDLE) || (state_d == ST_WAIT);
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign pixel_ready = ready_q;
    assign led_sdi     = led_sdi_q;
    assign busy        = busy_q;

`ifdef LED_WS_UNDERRUN_EN
    // Set has priority over a simultaneous clear.
    assign underrun_d = und_set ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;
`else
    logic unused_underrun;
    assign unused_underrun = underrun_clr ^ wait_done;
    assign underrun        = 1'b0;
`endif

endmodule

// File: tb/tb_led_ws_serializer.sv
`timescale 1ns/1ps

module tb_led_ws_serializer;

    localparam int T0H   = 35;
    localparam int T1H   = 70;
    localparam int BITC  = 125;
    localparam int LATCH = 5000;
    localparam int UND   = 2000;

    logic        clk_100      = 1'b0;
    logic        reset_n      = 1'b0;
    logic [23:0] pixel_data   = '0;
    logic        pixel_last   = 1'b0;
    logic        pixel_valid  = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        pixel_ready;
    logic        led_sdi;
    logic        busy;
    logic        underrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk_100 = ~clk_100;

    led_ws_serializer dut (
        .clk_100      (clk_100),
        .reset_n      (reset_n),
        .pixel_data   (pixel_data),
        .pixel_last   (pixel_last),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .led_sdi      (led_sdi),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: each accepted pixel expands into its line-level
    // sequence (one entry per cycle); the frame end appends the latch gap.
    // An empty sequence means the block can accept (IDLE or WAIT).
    // ------------------------------------------------------------------
    bit   mq[$];
    logic m_sdi = 0, m_level = 0, m_ready = 0, m_busy = 0, m_open = 0, m_und = 0;
    logic m_und_set = 0;
    int   m_wait = 0;

    task automatic push_pixel(input logic [23:0] d);
        for (int i = 23; i >= 0; i--) begin
            int th;
            th = d[i] ? T1H : T0H;
            for (int c = 0; c < BITC; c++) mq.push_back(c < th);
        end
    endtask

    task automatic push_latch();
        for (int c = 0; c < LATCH; c++) mq.push_back(1'b0);
    endtask

    always @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_sdi = 0; m_level = 0; m_ready = 0; m_busy = 0;
            m_open = 0; m_und = 0; m_wait = 0;
        end else begin
            m_und_set = 0;
            m_sdi = m_level;
            if (m_ready && pixel_valid) begin
                push_pixel(pixel_data);
                if (pixel_last) push_latch();
                m_open = !pixel_last;
            end
`ifdef LED_WS_UNDERRUN_EN
            else if (m_ready && m_open && m_wait == UND) begin
                m_und_set = 1;
                push_latch();
                m_open = 0;
            end
`endif
            if (mq.size() > 0) begin
                m_level = mq.pop_front();
                m_ready = 0;
                m_busy  = 1;
                m_wait  = 0;
            end else begin
                m_level = 0;
                m_ready = 1;
                m_busy  = m_open;
                m_wait  = m_open ? m_wait + 1 : 0;
            end
`ifdef LED_WS_UNDERRUN_EN
            if (m_und_set) m_und = 1;
            else if (underrun_clr) m_und = 0;
`endif
        end
    end

    // Per-cycle comparison against the model, plus waveform measurement.
    int cyc = 0, rise_t = -1, busy_cnt = 0;
    logic prev_sdi = 0;
    int wid_q[$], per_q[$];

    always @(negedge clk_100) begin
        check("led_sdi", led_sdi, m_sdi);
        check("pixel_ready", pixel_ready, m_ready);
        check("busy", busy, m_busy);
        check("underrun", underrun, m_und);
        cyc++;
        if (busy) busy_cnt++;
        if (led_sdi && !prev_sdi) begin
            if (rise_t >= 0) per_q.push_back(cyc - rise_t);
            rise_t = cyc;
        end
        if (!led_sdi && prev_sdi) wid_q.push_back(cyc - rise_t);
        prev_sdi = led_sdi;
    end

    task automatic clear_meas();
        wid_q.delete(); per_q.delete(); rise_t = -1; busy_cnt = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_100);
        #1;
    endtask

    // Offer a pixel; return 1 ns after the edge that accepts it.
    task automatic send(input logic [23:0] d, input logic l, input bit hold);
        int n;
        n = 0;
        pixel_data  = d;
        pixel_last  = l;
        pixel_valid = 1'b1;
        @(negedge clk_100);
        while (!pixel_ready && n < 20000) begin
            n++;
            @(negedge clk_100);
        end
        check("accept_timeout", pixel_ready, 1);
        @(posedge clk_100);
        #1;
        if (!hold) pixel_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk_100);
        while ((busy || !pixel_ready) && n < budget) begin
            n++;
            @(negedge clk_100);
        end
        check("idle_timeout", {busy, pixel_ready}, 2'b01);
        @(posedge clk_100);
        #1;
    endtask

    int a5w[8] = '{70, 35, 70, 35, 35, 70, 35, 70};

    initial begin
        // Reset state
        cycles(3);
        @(negedge clk_100);
        check("rst_led_sdi", led_sdi, 0);
        check("rst_ready", pixel_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        @(posedge clk_100); #1;
        reset_n = 1'b1;
        cycles(2);

        // Single pixel 0xA50000, last
        clear_meas();
        send(24'hA50000, 1'b1, 1'b0);
        wait_idle(20000);
        check("t1_pulse_count", wid_q.size(), 24);
        check("t1_period_count", per_q.size(), 23);
        for (int i = 0; i < 24 && i < wid_q.size(); i++)
            check("t1_high_width", wid_q[i], (i < 8) ? a5w[i] : 35);
        for (int i = 0; i < per_q.size(); i++)
            check("t1_period", per_q[i], 125);
        check("t1_busy_cycles", busy_cnt, 8000);

        // 0xFFFFFF then 0x000000 (last), valid held
        clear_meas();
        send(24'hFFFFFF, 1'b0, 1'b1);
        send(24'h000000, 1'b1, 1'b0);
        wait_idle(20000);
        check("t2_pulse_count", wid_q.size(), 48);
        for (int i = 0; i < wid_q.size(); i++)
            check("t2_high_width", wid_q[i], (i < 24) ? 70 : 35);
        for (int i = 0; i < per_q.size(); i++)
            check("t2_period", per_q[i], (i == 23) ? 126 : 125);

        // Valid held through the latch gap
        clear_meas();
        send(24'h123456, 1'b1, 1'b1);
        send(24'h00F00F, 1'b1, 1'b0);
        wait_idle(20000);
        check("t3_period_count", per_q.size(), 47);
        if (per_q.size() > 23) check("t3_latch_period", per_q[23], 5126);

        // Reset during the high phase of bit 12
        send(24'hFFFFFF, 1'b1, 1'b0);
        cycles(11 * BITC + 20);
        check("t4_high_before_reset", led_sdi, 1);
        reset_n = 1'b0;
        #1;
        check("t4_async_sdi", led_sdi, 0);
        check("t4_async_ready", pixel_ready, 0);
        cycles(2);
        reset_n = 1'b1;
        clear_meas();
        cycles(300);
        check("t4_no_residual", wid_q.size(), 0);
        check("t4_ready_after", pixel_ready, 1);
        check("t4_busy_after", busy, 0);

        // Frame left open by upstream
        send(24'hC3C3C3, 1'b0, 1'b0);
`ifdef LED_WS_UNDERRUN_EN
        cycles(4998);
        check("t5_underrun_early", underrun, 0);
        cycles(2);
        check("t5_underrun_set", underrun, 1);
        check("t5_ready_latch", pixel_ready, 0);
        wait_idle(6000);
        check("t5_underrun_sticky", underrun, 1);
        underrun_clr = 1'b1;
        cycles(1);
        underrun_clr = 1'b0;
        check("t5_underrun_clr", underrun, 0);
        send(24'h3C3C3C, 1'b0, 1'b0);
        underrun_clr = 1'b1;
        cycles(5000);
        check("t5_set_beats_clr", underrun, 1);
        cycles(1);
        check("t5_clr_after", underrun, 0);
        underrun_clr = 1'b0;
        wait_idle(6000);
`else
        cycles(5500);
        check("t5_wait_busy", busy, 1);
        check("t5_wait_ready", pixel_ready, 1);
        check("t5_wait_sdi", led_sdi, 0);
        check("t5_no_underrun", underrun, 0);
        clear_meas();
        send(24'h5A5A5A, 1'b1, 1'b0);
        wait_idle(20000);
        check("t5_late_pixel_pulses", wid_q.size(), 24);
`endif

        // Randomized frames against the model
        for (int f = 0; f < 2; f++) begin
            int np;
            np = $urandom_range(1, 2);
            for (int p = 0; p < np; p++) begin
                int gap;
                gap = $urandom_range(0, 12);
                for (int g = 0; g < gap; g++) begin
                    if (!pixel_valid) pixel_data = 24'($urandom);
                    underrun_clr = 1'($urandom_range(0, 1));
                    cycles(1);
                end
                underrun_clr = 1'b0;
                send(24'($urandom), (p == np - 1), (p != np - 1) && ($urandom_range(0, 1) == 1));
            end
            wait_idle(20000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
